// File: rtl/opb_register_ppc2user.sv
// OPB slave register bank, PPC-to-fabric direction.
// The processor writes a 32-bit control word (DATA). User logic sees it as
// user_data_out, with user_data_valid pulsing once for each accepted write.
// A read-only COUNT register tracks accepted DATA writes so software can
// confirm they landed.
//
// state | meaning
// IDLE  | waiting for a decoded select
// ACK   | Sl_xferAck high for one cycle; read data was latched and any write
//       | was committed on the edge that entered this state
// GAP   | one dead cycle while the master drops select
module opb_register_ppc2user #(
  parameter logic [31:0] C_BASEADDR   = 32'h01080200,
  parameter logic [31:0] C_HIGHADDR   = 32'h010802FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex5",
  parameter logic [31:0] C_INIT_VALUE = 32'h00000000
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  output logic [31:0] user_data_out,
  output logic        user_data_valid
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] sl_dbus_q, sl_dbus_d;
  logic        data_valid_q, data_valid_d;
  logic [31:0] user_data_q, user_data_d;
  logic [31:0] write_count_q, write_count_d;

  logic        hit;
  logic [31:0] addr_off;
  logic        is_data;
  logic        is_count;
  logic [31:0] wr_word;
  logic        unused_ok;

  // Address decode; the word offset is taken relative to the base so the
  // two low byte-address bits never matter.
  always_comb begin
    hit      = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    addr_off = OPB_ABus - C_BASEADDR;
    is_data  = (addr_off[31:2] == 30'd0);
    is_count = (addr_off[31:2] == 30'd1);
    // OPB bit 0 is the MSB, so a plain numeric copy puts DBus[0] at bit 31.
    wr_word  = OPB_DBus;
  end

  // Next-state logic; read data and write commit both happen on the edge
  // that enters ACK, so Sl_DBus is non-zero only during the ack cycle.
  always_comb begin
    state_d       = state_q;
    sl_dbus_d     = 32'h0;
    data_valid_d  = 1'b0;
    user_data_d   = user_data_q;
    write_count_d = write_count_q;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d = ST_ACK;
          if (OPB_RNW) begin
            if (is_data) begin
              sl_dbus_d = user_data_q;
            end else if (is_count) begin
              sl_dbus_d = write_count_q;
            end
          end else if (is_data && (OPB_BE != 4'b0000)) begin
            for (int i = 0; i < 4; i++) begin
              if (OPB_BE[i]) begin
                user_data_d[31-8*i -: 8] = wr_word[31-8*i -: 8];
              end
            end
            data_valid_d  = 1'b1;
            write_count_d = write_count_q + 32'd1;
          end
        end
      end
      ST_ACK:  state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and register flops; reset takes effect without waiting for a clock.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q       <= ST_IDLE;
      sl_dbus_q     <= 32'h0;
      data_valid_q  <= 1'b0;
      user_data_q   <= C_INIT_VALUE;
      write_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      sl_dbus_q     <= sl_dbus_d;
      data_valid_q  <= data_valid_d;
      user_data_q   <= user_data_d;
      write_count_q <= write_count_d;
    end
  end

  assign Sl_DBus         = sl_dbus_q;
  assign Sl_xferAck      = (state_q == ST_ACK);
  assign Sl_errAck       = 1'b0;
  assign Sl_retry        = 1'b0;
  assign Sl_toutSup      = 1'b0;
  assign user_data_out   = user_data_q;
  assign user_data_valid = data_valid_q;

  // Burst hint, byte-offset bits and informational parameters are not used.
  assign unused_ok = &{1'b0, OPB_seqAddr, addr_off[1:0], (C_FAMILY == ""),
                       (C_OPB_AWIDTH != 32), (C_OPB_DWIDTH != 32)};

endmodule

// File: tb/tb_opb_register_ppc2user.sv
// Directed bench for opb_register_ppc2user.
module tb_opb_register_ppc2user;

  localparam logic [31:0] A_DATA  = 32'h01080200;
  localparam logic [31:0] A_COUNT = 32'h01080204;
  localparam logic [31:0] A_UNUSE = 32'h01080208;
  localparam logic [31:0] A_OUT   = 32'h01080300;

  logic        OPB_Clk = 1'b0;
  logic        OPB_Rst;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic [31:0] user_data_out;
  logic        user_data_valid;

  int nvec = 0;
  int nerr = 0;

  opb_register_ppc2user dut (
    .OPB_Clk         (OPB_Clk),
    .OPB_Rst         (OPB_Rst),
    .OPB_ABus        (OPB_ABus),
    .OPB_BE          (OPB_BE),
    .OPB_DBus        (OPB_DBus),
    .OPB_RNW         (OPB_RNW),
    .OPB_select      (OPB_select),
    .OPB_seqAddr     (OPB_seqAddr),
    .Sl_DBus         (Sl_DBus),
    .Sl_xferAck      (Sl_xferAck),
    .Sl_errAck       (Sl_errAck),
    .Sl_retry        (Sl_retry),
    .Sl_toutSup      (Sl_toutSup),
    .user_data_out   (user_data_out),
    .user_data_valid (user_data_valid)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transfer from IDLE: drive at a negedge, sample the ack cycle at the
  // next negedge, then sample the GAP cycle and idle until back in IDLE.
  task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [3:0] be,
                      input logic [31:0] wdata,
                      output logic ack, output logic [31:0] rdata, output logic valid,
                      output logic gap_ack, output logic [31:0] gap_dbus, output logic gap_valid);
    @(negedge OPB_Clk);
    OPB_ABus   = addr;
    OPB_RNW    = rnw;
    OPB_BE     = be;
    OPB_DBus   = wdata;
    OPB_select = 1'b1;
    @(negedge OPB_Clk);
    ack   = Sl_xferAck;
    rdata = Sl_DBus;
    valid = user_data_valid;
    OPB_select = 1'b0;
    OPB_DBus   = 32'h0;
    @(negedge OPB_Clk);
    gap_ack   = Sl_xferAck;
    gap_dbus  = Sl_DBus;
    gap_valid = user_data_valid;
    @(negedge OPB_Clk);
  endtask

  logic        ack, valid, gack, gvalid;
  logic [31:0] rd, gdbus;
  int          ack_cnt, bad_cnt;
  logic [8:0]  pattern;

  initial begin
    OPB_Rst     = 1'b1;
    OPB_ABus    = 32'h0;
    OPB_BE      = 4'b0000;
    OPB_DBus    = 32'h0;
    OPB_RNW     = 1'b1;
    OPB_select  = 1'b0;
    OPB_seqAddr = 1'b0;

    @(negedge OPB_Clk);
    chk("rst_ack",   {31'h0, Sl_xferAck}, 32'h0);
    chk("rst_dbus",  Sl_DBus, 32'h0);
    chk("rst_udo",   user_data_out, 32'h0);
    chk("rst_valid", {31'h0, user_data_valid}, 32'h0);
    chk("tie_offs",  {29'h0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'h0);
    OPB_Rst = 1'b0;

    // Reads after reset
    xfer(A_DATA, 1'b1, 4'b1111, 32'h0, ack, rd, valid, gack, gdbus, gvalid);
    chk("rd0_ack",   {31'h0, ack}, 32'h1);
    chk("rd0_data",  rd, 32'h0);
    chk("rd0_gack",  {31'h0, gack}, 32'h0);
    xfer(A_COUNT, 1'b1, 4'b1111, 32'h0, ack, rd, valid, gack, gdbus, gvalid);
    chk("cnt0",      rd, 32'h0);

    // Full-word write
    xfer(A_DATA, 1'b0, 4'b1111, 32'hDEADBEEF, ack, rd, valid, gack, gdbus, gvalid);
    chk("wr1_ack",    {31'h0, ack}, 32'h1);
    chk("wr1_valid",  {31'h0, valid}, 32'h1);
    chk("wr1_dbus",   rd, 32'h0);
    chk("wr1_gvalid", {31'h0, gvalid}, 32'h0);
    chk("wr1_gdbus",  gdbus, 32'h0);
    chk("wr1_udo",    user_data_out, 32'hDEADBEEF);
    xfer(A_COUNT, 1'b1, 4'b1111, 32'h0, ack, rd, valid, gack, gdbus, gvalid);
    chk("cnt1",       rd, 32'h1);
    xfer(A_DATA, 1'b1, 4'b1111, 32'h0, ack, rd, valid, gack, gdbus, gvalid);
    chk("rd1_data",   rd, 32'hDEADBEEF);
    chk("rd1_gdbus",  gdbus, 32'h0);

    // Partial write, lanes 1 and 3
    xfer(A_DATA, 1'b0, 4'b0101, 32'h11223344, ack, rd, valid, gack, gdbus, gvalid);
    chk("wr2_valid",  {31'h0, valid}, 32'h1);
    chk("wr2_udo",    user_data_out, 32'hDE22BE44);
    xfer(A_COUNT, 1'b1, 4'b1111, 32'h0, ack, rd, valid, gack, gdbus, gvalid);
    chk("cnt2",       rd, 32'h2);

    // Empty byte-enable write
    xfer(A_DATA, 1'b0, 4'b0000, 32'hFFFFFFFF, ack, rd, valid, gack, gdbus, gvalid);
    chk("wr3_ack",    {31'h0, ack}, 32'h1);
    chk("wr3_valid",  {31'h0, valid}, 32'h0);
    chk("wr3_udo",    user_data_out, 32'hDE22BE44);

    // Writes to COUNT and an unused offset are acked but change nothing
    xfer(A_COUNT, 1'b0, 4'b1111, 32'h55555555, ack, rd, valid, gack, gdbus, gvalid);
    chk("wrc_ack",    {31'h0, ack}, 32'h1);
    chk("wrc_valid",  {31'h0, valid}, 32'h0);
    xfer(A_UNUSE, 1'b0, 4'b1111, 32'h66666666, ack, rd, valid, gack, gdbus, gvalid);
    chk("wru_ack",    {31'h0, ack}, 32'h1);
    chk("wru_udo",    user_data_out, 32'hDE22BE44);
    xfer(A_UNUSE, 1'b1, 4'b1111, 32'h0, ack, rd, valid, gack, gdbus, gvalid);
    chk("rdu_ack",    {31'h0, ack}, 32'h1);
    chk("rdu_data",   rd, 32'h0);
    xfer(A_COUNT, 1'b1, 4'b1111, 32'h0, ack, rd, valid, gack, gdbus, gvalid);
    chk("cnt2b",      rd, 32'h2);

    // Byte enables do not mask reads
    xfer(A_DATA, 1'b1, 4'b0000, 32'h0, ack, rd, valid, gack, gdbus, gvalid);
    chk("rd_be0",     rd, 32'hDE22BE44);

    // Out-of-range select held 10 cycles
    ack_cnt = 0;
    bad_cnt = 0;
    @(negedge OPB_Clk);
    OPB_ABus   = A_OUT;
    OPB_RNW    = 1'b1;
    OPB_BE     = 4'b1111;
    OPB_select = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge OPB_Clk);
      if (Sl_xferAck) ack_cnt++;
      if (Sl_DBus != 32'h0) bad_cnt++;
    end
    OPB_select = 1'b0;
    chk("oor_acks",   ack_cnt, 0);
    chk("oor_dbus",   bad_cnt, 0);

    // Select held at DATA: one ack every third cycle
    bad_cnt = 0;
    @(negedge OPB_Clk);
    OPB_ABus   = A_DATA;
    OPB_RNW    = 1'b1;
    OPB_select = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge OPB_Clk);
      pattern[8-i] = Sl_xferAck;
      if (Sl_DBus != (Sl_xferAck ? 32'hDE22BE44 : 32'h0)) bad_cnt++;
    end
    OPB_select = 1'b0;
    chk("held_pattern", {23'h0, pattern}, {23'h0, 9'b100100100});
    chk("held_dbus",    bad_cnt, 0);
    @(negedge OPB_Clk);

    // Reset in the middle of a write's ack cycle
    @(negedge OPB_Clk);
    OPB_ABus   = A_DATA;
    OPB_RNW    = 1'b0;
    OPB_BE     = 4'b1111;
    OPB_DBus   = 32'hCAFEF00D;
    OPB_select = 1'b1;
    @(posedge OPB_Clk);
    #2;
    chk("mid_ack",    {31'h0, Sl_xferAck}, 32'h1);
    chk("mid_valid",  {31'h0, user_data_valid}, 32'h1);
    chk("mid_udo",    user_data_out, 32'hCAFEF00D);
    OPB_Rst = 1'b1;
    #1;
    chk("arst_ack",   {31'h0, Sl_xferAck}, 32'h0);
    chk("arst_valid", {31'h0, user_data_valid}, 32'h0);
    chk("arst_udo",   user_data_out, 32'h0);
    OPB_select = 1'b0;
    @(negedge OPB_Clk);
    OPB_Rst = 1'b0;
    xfer(A_COUNT, 1'b1, 4'b1111, 32'h0, ack, rd, valid, gack, gdbus, gvalid);
    chk("arst_cnt",   rd, 32'h0);
    xfer(A_DATA, 1'b1, 4'b1111, 32'h0, ack, rd, valid, gack, gdbus, gvalid);
    chk("arst_data",  rd, 32'h0);

    // Counter wrap
    @(negedge OPB_Clk);
    force dut.write_count_q = 32'hFFFFFFFF;
    #1;
    release dut.write_count_q;
    xfer(A_COUNT, 1'b1, 4'b1111, 32'h0, ack, rd, valid, gack, gdbus, gvalid);
    chk("cnt_max",    rd, 32'hFFFFFFFF);
    xfer(A_DATA, 1'b0, 4'b1111, 32'h12345678, ack, rd, valid, gack, gdbus, gvalid);
    chk("wrap_udo",   user_data_out, 32'h12345678);
    xfer(A_COUNT, 1'b1, 4'b1111, 32'h0, ack, rd, valid, gack, gdbus, gvalid);
    chk("cnt_wrap",   rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
